// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the memory-access stage.
//   MEM_OP_*        : 3-bit load/store op encodings driven by execute
//   mem_state_e     : mem_stage handshake FSM states
//   DATA_W_DEF /
//   REG_ADDR_W_DEF  : default widths for the stage parameters
//   mem_is_store    : op is st_w / st_b
//   mem_misaligned  : op/address pair violates natural alignment
package mem_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [2:0] MEM_OP_NONE  = 3'b000;
    localparam logic [2:0] MEM_OP_LD_W  = 3'b001;
    localparam logic [2:0] MEM_OP_LD_B  = 3'b010;
    localparam logic [2:0] MEM_OP_LD_BU = 3'b011;
    localparam logic [2:0] MEM_OP_LD_H  = 3'b100;
    localparam logic [2:0] MEM_OP_LD_HU = 3'b101;
    localparam logic [2:0] MEM_OP_ST_W  = 3'b110;
    localparam logic [2:0] MEM_OP_ST_B  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } mem_state_e;

    function automatic logic mem_is_store(input logic [2:0] op);
        return (op == MEM_OP_ST_W) || (op == MEM_OP_ST_B);
    endfunction

    // Word ops need addr[1:0]==0, half ops need addr[0]==0; bytes never fault.
    function automatic logic mem_misaligned(input logic [2:0] op, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        case (op)
            MEM_OP_LD_W, MEM_OP_ST_W:  bad = (a != 2'b00);
            MEM_OP_LD_H, MEM_OP_LD_HU: bad = a[0];
            default:                   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align -- extracts and extends the loaded value from an SRAM word.
//   rdata   : raw data word returned by the SRAM
//   addr_lo : byte offset of the access within the word
//   op      : MEM_OP_* of the load
//   ld_val  : value to write back (0 for non-load ops)
module load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] ld_val
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
        ld_val   = '0;
        case (op)
            MEM_OP_LD_W:  ld_val = rdata;
            MEM_OP_LD_B:  ld_val = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            MEM_OP_LD_BU: ld_val = {{(DATA_W-8){1'b0}}, byte_sel};
            MEM_OP_LD_H:  ld_val = {{(DATA_W-16){half_sel[15]}}, half_sel};
            MEM_OP_LD_HU: ld_val = {{(DATA_W-16){1'b0}}, half_sel};
            default:      ld_val = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage between execute and register writeback.
// Holds one instruction; memory ops walk IDLE->REQ->WAIT->IDLE over the
// data SRAM req/addr_ok/data_ok handshake, non-memory ops write back the
// cycle after accept. Flushed accesses already accepted by the SRAM drain
// through DROP so the late data_ok is swallowed.
//   clk, resetn           : clock, async active-low reset
//   flush                 : cancel the held instruction
//   ex_valid / ex_ready   : execute-side handshake
//   alu_result_i ..wreg_i : instruction payload from execute
//   data_sram_*           : data SRAM request / response
//   wb_*                  : one-cycle writeback packet
//   ale                   : alignment exception pulse
// Build option: MEM_STAGE_ALIGN_CHECK_EN -- trap misaligned word/half
// accesses instead of issuing them truncated.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic [DATA_W-1:0]     store_data_i,
    input  logic [2:0]            mem_op_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    output logic                  data_sram_req,
    output logic                  data_sram_wr,
    output logic [DATA_W-1:0]     data_sram_addr,
    output logic [3:0]            data_sram_wstrb,
    output logic [DATA_W-1:0]     data_sram_wdata,
    input  logic                  data_sram_addr_ok,
    input  logic                  data_sram_data_ok,
    input  logic [DATA_W-1:0]     data_sram_rdata,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [DATA_W-1:0]     wb_wdata,
    output logic                  ale
);

    typedef struct packed {
        logic [2:0]            op;
        logic [DATA_W-1:0]     addr;
        logic [DATA_W-1:0]     sdata;
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
    } held_t;

    mem_state_e        state, state_nxt;
    held_t             held;
    logic              accept, is_mem, misalign, mem_done, wb_valid_q;
    logic [DATA_W-1:0] ld_val;

    assign ex_ready = (state == S_IDLE);
    assign accept   = ex_valid && ex_ready && !flush;
    assign is_mem   = (mem_op_i != MEM_OP_NONE);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    logic ale_q;
    assign misalign = is_mem && mem_misaligned(mem_op_i, alu_result_i[1:0]);
    assign ale      = ale_q && !(flush && state == S_IDLE);
`else
    assign misalign = 1'b0;
    assign ale      = 1'b0;
`endif

    // A flush while IDLE cancels the packet produced by the previous accept.
    assign wb_valid = wb_valid_q && !(flush && state == S_IDLE);

    // mem_done: the held access completes and must write back.
    always_comb begin
        state_nxt = state;
        mem_done  = 1'b0;
        case (state)
            S_IDLE: if (accept && is_mem && !misalign) state_nxt = S_REQ;
            S_REQ: begin
                if (flush) begin
                    // Accepted-but-unanswered requests still owe a data_ok.
                    state_nxt = (data_sram_addr_ok && !data_sram_data_ok) ? S_DROP : S_IDLE;
                end else if (data_sram_addr_ok) begin
                    if (data_sram_data_ok) begin
                        state_nxt = S_IDLE;
                        mem_done  = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_sram_data_ok) begin
                    state_nxt = S_IDLE;
                    mem_done  = !flush;
                end else if (flush) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: if (data_sram_data_ok) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            held       <= '0;
            wb_valid_q <= 1'b0;
            wb_wd      <= '0;
            wb_wreg    <= 1'b0;
            wb_wdata   <= '0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
            ale_q      <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            wb_valid_q <= 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
            ale_q      <= 1'b0;
`endif
            if (accept) begin
                held.op    <= mem_op_i;
                held.addr  <= alu_result_i;
                held.sdata <= store_data_i;
                held.wd    <= wd_i;
                held.wreg  <= wreg_i;
            end
            if (accept && (!is_mem || misalign)) begin
                wb_valid_q <= 1'b1;
                wb_wd      <= wd_i;
                wb_wreg    <= wreg_i && !misalign;
                wb_wdata   <= alu_result_i;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
                ale_q      <= misalign;
`endif
            end else if (mem_done) begin
                wb_valid_q <= 1'b1;
                wb_wd      <= held.wd;
                wb_wreg    <= held.wreg && !mem_is_store(held.op);
                wb_wdata   <= ld_val;
            end
        end
    end

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .rdata   (data_sram_rdata),
        .addr_lo (held.addr[1:0]),
        .op      (held.op),
        .ld_val  (ld_val)
    );

    // Request fields come only from held registers, so they stay stable in REQ.
    assign data_sram_req  = (state == S_REQ);
    assign data_sram_wr   = mem_is_store(held.op);
    assign data_sram_addr = {held.addr[DATA_W-1:2], 2'b00};

    always_comb begin
        data_sram_wstrb = 4'b0000;
        data_sram_wdata = '0;
        case (held.op)
            MEM_OP_ST_W: begin
                data_sram_wstrb = 4'b1111;
                data_sram_wdata = held.sdata;
            end
            MEM_OP_ST_B: begin
                data_sram_wstrb = 4'b0001 << held.addr[1:0];
                data_sram_wdata = {(DATA_W/8){held.sdata[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed self-checking bench for mem_stage.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. Build with MEM_STAGE_ALIGN_CHECK_EN to exercise the trap path.
module tb_mem_stage;
    import mem_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          resetn;
    logic          flush, ex_valid, ex_ready, wreg_i;
    logic [DW-1:0] alu_result_i, store_data_i;
    logic [2:0]    mem_op_i;
    logic [RW-1:0] wd_i;
    logic          data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
    logic [DW-1:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic [3:0]    data_sram_wstrb;
    logic          wb_valid, wb_wreg, ale;
    logic [RW-1:0] wb_wd;
    logic [DW-1:0] wb_wdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(DW), .REG_ADDR_W(RW)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .flush             (flush),
        .ex_valid          (ex_valid),
        .ex_ready          (ex_ready),
        .alu_result_i      (alu_result_i),
        .store_data_i      (store_data_i),
        .mem_op_i          (mem_op_i),
        .wd_i              (wd_i),
        .wreg_i            (wreg_i),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_valid          (wb_valid),
        .wb_wd             (wb_wd),
        .wb_wreg           (wb_wreg),
        .wb_wdata          (wb_wdata),
        .ale               (ale)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic offer(input logic [2:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] wd, input logic wr);
        ex_valid     = 1'b1;
        mem_op_i     = op;
        alu_result_i = a;
        store_data_i = sd;
        wd_i         = wd;
        wreg_i       = wr;
    endtask

    initial begin
        resetn = 1'b0;
        flush = 1'b0; ex_valid = 1'b0; mem_op_i = 3'b000; alu_result_i = '0;
        store_data_i = '0; wd_i = '0; wreg_i = 1'b0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        #2;
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_req",      32'(data_sram_req), 32'd0);
        check("rst_wstrb",    32'(data_sram_wstrb), 32'd0);
        check("rst_wb_wdata", wb_wdata, 32'd0);
        check("rst_ale",      32'(ale), 32'd0);
        @(posedge clk); cyc();
        resetn = 1'b1;
        mid(); check("rst_ex_ready", 32'(ex_ready), 32'd1);
        cyc();

        // Back-to-back non-memory ops
        offer(MEM_OP_NONE, 32'h0101_0101, 0, 5'd10, 1'b1);
        mid(); check("nm_ready0", 32'(ex_ready), 32'd1);
        cyc();
        offer(MEM_OP_NONE, 32'h1010_1010, 0, 5'd11, 1'b1);
        mid(); check("nm0_valid", 32'(wb_valid), 32'd1);
        check("nm0_data", wb_wdata, 32'h0101_0101);
        check("nm0_wd", 32'(wb_wd), 32'd10);
        check("nm_ready1", 32'(ex_ready), 32'd1);
        cyc();
        offer(MEM_OP_NONE, 32'h1111_1111, 0, 5'd12, 1'b1);
        mid(); check("nm1_valid", 32'(wb_valid), 32'd1);
        check("nm1_data", wb_wdata, 32'h1010_1010);
        check("nm1_wd", 32'(wb_wd), 32'd11);
        cyc();
        ex_valid = 1'b0;
        mid(); check("nm2_valid", 32'(wb_valid), 32'd1);
        check("nm2_data", wb_wdata, 32'h1111_1111);
        check("nm2_wd", 32'(wb_wd), 32'd12);
        check("nm2_wreg", 32'(wb_wreg), 32'd1);
        cyc();
        mid(); check("nm_pulse_end", 32'(wb_valid), 32'd0);
        check("nm_hold", wb_wdata, 32'h1111_1111);
        cyc();

        // ld_b 0x1003, addr_ok one cycle late, data_ok two cycles after that
        offer(MEM_OP_LD_B, 32'h0000_1003, 0, 5'd5, 1'b1);
        mid(); check("ldb_no_req_on_accept", 32'(data_sram_req), 32'd0);
        cyc();
        ex_valid = 1'b0;
        mid(); check("ldb_req", 32'(data_sram_req), 32'd1);
        check("ldb_addr", data_sram_addr, 32'h0000_1000);
        check("ldb_wr", 32'(data_sram_wr), 32'd0);
        check("ldb_ready_req", 32'(ex_ready), 32'd0);
        cyc();
        data_sram_addr_ok = 1'b1;
        mid(); check("ldb_req_held", 32'(data_sram_req), 32'd1);
        cyc();
        data_sram_addr_ok = 1'b0;
        mid(); check("ldb_req_drop", 32'(data_sram_req), 32'd0);
        check("ldb_ready_wait", 32'(ex_ready), 32'd0);
        cyc();
        mid(); check("ldb_no_wb_yet", 32'(wb_valid), 32'd0);
        cyc();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_FFFF;
        mid(); check("ldb_ready_dok", 32'(ex_ready), 32'd0);
        cyc();
        data_sram_data_ok = 1'b0;
        mid(); check("ldb_wb_valid", 32'(wb_valid), 32'd1);
        check("ldb_wb_data", wb_wdata, 32'hFFFF_FF80);
        check("ldb_wb_wd", 32'(wb_wd), 32'd5);
        check("ldb_ready_done", 32'(ex_ready), 32'd1);
        cyc();

        // st_b 0x2002 data 0xAB
        offer(MEM_OP_ST_B, 32'h0000_2002, 32'h0000_00AB, 5'd6, 1'b1);
        mid(); cyc();
        ex_valid = 1'b0; data_sram_addr_ok = 1'b1;
        mid(); check("stb_req", 32'(data_sram_req), 32'd1);
        check("stb_wr", 32'(data_sram_wr), 32'd1);
        check("stb_wstrb", 32'(data_sram_wstrb), 32'h4);
        check("stb_wdata", data_sram_wdata, 32'hABAB_ABAB);
        check("stb_addr", data_sram_addr, 32'h0000_2000);
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = '0;
        mid(); cyc();
        data_sram_data_ok = 1'b0;
        mid(); check("stb_wb_valid", 32'(wb_valid), 32'd1);
        check("stb_wb_wreg", 32'(wb_wreg), 32'd0);
        check("stb_wb_wd", 32'(wb_wd), 32'd6);
        cyc();

        // ld_hu 0x3002 with addr_ok and data_ok together
        offer(MEM_OP_LD_HU, 32'h0000_3002, 0, 5'd7, 1'b1);
        mid(); cyc();
        ex_valid = 1'b0; data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h8001_1234;
        mid(); check("ldhu_addr", data_sram_addr, 32'h0000_3000);
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        mid(); check("ldhu_wb_valid", 32'(wb_valid), 32'd1);
        check("ldhu_wb_data", wb_wdata, 32'h0000_8001);
        check("ldhu_wb_wreg", 32'(wb_wreg), 32'd1);
        cyc();

        // flush in WAIT, data_ok three cycles later
        offer(MEM_OP_LD_W, 32'h0000_5000, 0, 5'd8, 1'b1);
        mid(); cyc();
        ex_valid = 1'b0; data_sram_addr_ok = 1'b1;
        mid(); cyc();
        data_sram_addr_ok = 1'b0; flush = 1'b1;
        mid(); check("fw_ready_wait", 32'(ex_ready), 32'd0);
        cyc();
        flush = 1'b0;
        mid(); check("fw_ready_drop1", 32'(ex_ready), 32'd0);
        cyc();
        mid(); check("fw_ready_drop2", 32'(ex_ready), 32'd0);
        cyc();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
        mid(); check("fw_ready_drop3", 32'(ex_ready), 32'd0);
        check("fw_no_wb_drop", 32'(wb_valid), 32'd0);
        cyc();
        data_sram_data_ok = 1'b0;
        mid(); check("fw_no_wb", 32'(wb_valid), 32'd0);
        check("fw_ready_back", 32'(ex_ready), 32'd1);
        check("fw_wd_kept", 32'(wb_wd), 32'd7);
        cyc();

        // flush in REQ before addr_ok
        offer(MEM_OP_LD_W, 32'h0000_6000, 0, 5'd9, 1'b1);
        mid(); cyc();
        ex_valid = 1'b0; flush = 1'b1;
        mid(); check("fr_req", 32'(data_sram_req), 32'd1);
        cyc();
        flush = 1'b0;
        mid(); check("fr_req_gone", 32'(data_sram_req), 32'd0);
        check("fr_ready", 32'(ex_ready), 32'd1);
        check("fr_no_wb", 32'(wb_valid), 32'd0);
        cyc();

        // flush in IDLE suppresses a same-cycle accept
        offer(MEM_OP_NONE, 32'h0000_0077, 0, 5'd9, 1'b1);
        flush = 1'b1;
        mid(); cyc();
        ex_valid = 1'b0; flush = 1'b0;
        mid(); check("fi_no_wb", 32'(wb_valid), 32'd0);
        check("fi_wd_kept", 32'(wb_wd), 32'd7);
        cyc();

        // flush in IDLE kills the pending packet of the previous accept
        offer(MEM_OP_NONE, 32'h0000_0088, 0, 5'd3, 1'b1);
        mid(); cyc();
        ex_valid = 1'b0; flush = 1'b1;
        mid(); check("fk_killed", 32'(wb_valid), 32'd0);
        cyc();
        flush = 1'b0;
        mid(); check("fk_after", 32'(wb_valid), 32'd0);
        cyc();

        // misaligned ld_w at 0x4001
        offer(MEM_OP_LD_W, 32'h0000_4001, 0, 5'd4, 1'b1);
        mid(); cyc();
        ex_valid = 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        mid(); check("al_no_req", 32'(data_sram_req), 32'd0);
        check("al_ale", 32'(ale), 32'd1);
        check("al_wb_valid", 32'(wb_valid), 32'd1);
        check("al_wb_wreg", 32'(wb_wreg), 32'd0);
        cyc();
        mid(); check("al_ale_pulse", 32'(ale), 32'd0);
        check("al_ready", 32'(ex_ready), 32'd1);
        cyc();
`else
        mid(); check("al_req", 32'(data_sram_req), 32'd1);
        check("al_addr", data_sram_addr, 32'h0000_4000);
        check("al_ale", 32'(ale), 32'd0);
        data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678;
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        mid(); check("al_wb_valid", 32'(wb_valid), 32'd1);
        check("al_wb_data", wb_wdata, 32'h1234_5678);
        check("al_ale_wb", 32'(ale), 32'd0);
        cyc();
`endif

        // asynchronous reset while waiting for data
        offer(MEM_OP_LD_W, 32'h0000_7000, 0, 5'd2, 1'b1);
        mid(); cyc();
        ex_valid = 1'b0; data_sram_addr_ok = 1'b1;
        mid(); cyc();
        data_sram_addr_ok = 1'b0;
        mid(); check("ar_ready_wait", 32'(ex_ready), 32'd0);
        #1 resetn = 1'b0;
        #1;
        check("ar_ready", 32'(ex_ready), 32'd1);
        check("ar_req", 32'(data_sram_req), 32'd0);
        check("ar_wb_data", wb_wdata, 32'd0);
        check("ar_addr", data_sram_addr, 32'd0);
        cyc();
        resetn = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
